// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative data cache controller.
// The cache address is {tag, index, word offset}.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } state_t;

    localparam int TAG_W   = 11;
    localparam int IDX_W   = 6;
    localparam int LINE_W  = 64;
    localparam int WORD_W  = 32;
    localparam int CADDR_W = TAG_W + IDX_W + 1;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Data-cache controller between MEM stage and SRAM: read hits in one cycle,
// read misses fill a 64-bit line, writes go straight through and invalidate.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_BASE = 1024,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [17:0]        cache_address,
    output logic               cache_writeEn,
    output logic               cache_invalidate,
    output logic               cache_LRU_update,
    output logic [63:0]        cache_WriteData,
    input  logic [31:0]        cache_ReadData,
    input  logic               cache_hit,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [31:0]        sram_address,
    output logic [31:0]        sram_wdata,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    state_t state;
    state_t state_next;

    logic [31:0]       rel;
    logic              offset;
    logic              rd_req;
    logic              wr_req;
    logic              hit_inc;
    logic              miss_inc;
    logic [WORD_W-1:0] fill_word;

    assign rel       = address - 32'(ADDR_BASE);
    assign offset    = rel[2];
    assign rd_req    = MEM_R_EN && !MEM_W_EN;
    assign wr_req    = MEM_W_EN;
    assign fill_word = offset ? sram_rdata[LINE_W-1:WORD_W] : sram_rdata[WORD_W-1:0];

    // The pipeline holds its inputs while frozen, so the live address is valid in every state.
    assign cache_address   = rel[CADDR_W+1:2];
    assign cache_WriteData = sram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    state_next = ST_WR_THRU;
                end else if (rd_req && !cache_hit) begin
                    state_next = ST_RD_MISS;
                end
            end
            ST_RD_MISS: begin
                if (sram_ready) state_next = ST_IDLE;
            end
            ST_WR_THRU: begin
                if (sram_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced to their idle values while reset is held so an
    // abandoned SRAM access is dropped at once, not on the next edge.
    always_comb begin
        ready            = 1'b1;
        rdata            = '0;
        cache_writeEn    = 1'b0;
        cache_invalidate = 1'b0;
        cache_LRU_update = 1'b0;
        sram_rd_en       = 1'b0;
        sram_wr_en       = 1'b0;
        sram_address     = '0;
        sram_wdata       = '0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        ready            = 1'b0;
                        cache_invalidate = cache_hit;
                    end else if (rd_req) begin
                        if (cache_hit) begin
                            rdata            = cache_ReadData;
                            cache_LRU_update = 1'b1;
                            hit_inc          = 1'b1;
                        end else begin
                            ready    = 1'b0;
                            miss_inc = 1'b1;
                        end
                    end
                end
                ST_RD_MISS: begin
                    sram_rd_en   = 1'b1;
                    sram_address = {rel[31:3], 3'b000};
                    ready        = sram_ready;
                    if (sram_ready) begin
                        cache_writeEn = 1'b1;
                        rdata         = fill_word;
                    end
                end
                ST_WR_THRU: begin
                    sram_wr_en   = 1'b1;
                    sram_address = rel;
                    sram_wdata   = wdata;
                    ready        = sram_ready;
                end
                default: ready = 1'b1;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .clear (1'b0),
        .count (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .clear (1'b0),
        .count (miss_count)
    );

endmodule
